// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with architectural HI/LO registers
// Optional feature: define MDU_DIV0_FLAG_EN to add the DivZero output.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic        Req,
`ifdef MDU_DIV0_FLAG_EN
    output logic        DivZero,
`endif
    output logic        Busy,
    output logic [31:0] MDUResult
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_hi_sh;
    logic [31:0]      r_lo_sh;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_accept;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_hi_next;
    logic [31:0] w_lo_next;

    assign w_is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign w_is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign w_accept = Start && (w_is_mul || w_is_div) && (r_state == ST_IDLE) && !Req;

    assign w_prod_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
    assign w_prod_u = {32'b0, SrcA} * {32'b0, SrcB};

    // Signed divide runs on magnitudes; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0.
    assign w_a_neg  = (MDUOp == OP_DIV) && SrcA[31];
    assign w_b_neg  = (MDUOp == OP_DIV) && SrcB[31];
    assign w_b_zero = (SrcB == 32'h0);
    assign w_a_mag  = w_a_neg ? (32'h0 - SrcA) : SrcA;
    assign w_b_mag  = w_b_neg ? (32'h0 - SrcB) : SrcB;
    assign w_b_safe = w_b_zero ? 32'h1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_q      = (w_a_neg ^ w_b_neg) ? (32'h0 - w_q_mag) : w_q_mag;
    assign w_r      = w_a_neg ? (32'h0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_hi_next = 32'h0;
        w_lo_next = 32'h0;
        if (MDUOp == OP_MULT) begin
            w_hi_next = w_prod_s[63:32];
            w_lo_next = w_prod_s[31:0];
        end else if (MDUOp == OP_MULTU) begin
            w_hi_next = w_prod_u[63:32];
            w_lo_next = w_prod_u[31:0];
        end else if (w_b_zero) begin
            w_hi_next = SrcA;
            w_lo_next = 32'hFFFF_FFFF;
        end else begin
            w_hi_next = w_r;
            w_lo_next = w_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= 32'h0;
            r_lo    <= 32'h0;
            r_hi_sh <= 32'h0;
            r_lo_sh <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hi_sh <= w_hi_next;
                        r_lo_sh <= w_lo_next;
                        r_cnt   <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        r_state <= ST_RUN;
                    end else if (!Req && (MDUOp == OP_MTHI)) begin
                        r_hi <= SrcA;
                    end else if (!Req && (MDUOp == OP_MTLO)) begin
                        r_lo <= SrcA;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_hi_sh;
                        r_lo    <= r_lo_sh;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MDU_DIV0_FLAG_EN
    logic r_div_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_div_zero <= w_is_div && w_b_zero;
        end
    end

    assign DivZero = r_div_zero;
`endif

    assign Busy      = (r_state == ST_RUN);
    assign MDUResult = (MDUOp == OP_MFHI) ? r_hi :
                       (MDUOp == OP_MFLO) ? r_lo : 32'h0;

endmodule
